// File: rtl/ask_demodulator.sv
// ---------------------------------------------------------------------------
// ask_demodulator
// Non-coherent on-off ASK receiver. Each 8-bit offset-binary sample is
// rectified about mid-scale and summed over one bit window of SAMPLES_PER_BIT
// valid samples. The sum is sliced against THRESH_AVG*SAMPLES_PER_BIT. A
// carrier-hunt FSM anchors the window grid to the first strong sample and
// drops lock after MAX_ZERO_BITS consecutive '0' decisions.
//
// Ports
//   sys_clk      in   clock, all logic on the rising edge
//   sys_rst      in   synchronous reset, active-high
//   ad_data[7:0] in   offset-binary sample, 128 = zero amplitude
//   ad_valid     in   sample qualifier
//   bit_out      out  recovered bit, holds its value between strobes
//   bit_valid    out  one-cycle strobe per completed window
//   carrier_det  out  high while locked
// ---------------------------------------------------------------------------
module ask_demodulator #(
  parameter int unsigned SAMPLES_PER_BIT = 40,
  parameter int unsigned DET_LEVEL       = 64,
  parameter int unsigned THRESH_AVG      = 40,
  parameter int unsigned MAX_ZERO_BITS   = 8
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [7:0] ad_data,
  input  logic       ad_valid,
  output logic       bit_out,
  output logic       bit_valid,
  output logic       carrier_det
);

  localparam int unsigned ACC_W = $clog2(128 * SAMPLES_PER_BIT + 1);
  localparam int unsigned CNT_W = $clog2(SAMPLES_PER_BIT + 1);
  localparam int unsigned ZC_W  = $clog2(MAX_ZERO_BITS + 1);
  localparam int unsigned TH    = THRESH_AVG * SAMPLES_PER_BIT;

  typedef enum logic [0:0] {
    ST_HUNT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t             r_state;
  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_sample_cnt;
  logic [ZC_W-1:0]    r_zero_cnt;
  logic               r_bit_out;
  logic               r_bit_valid;
  logic               r_carrier_det;

  logic [7:0]         w_rect;
  logic [ACC_W-1:0]   w_acc_next;
  logic               w_win_done;
  logic               w_bit;
  logic               w_detect;

  // |ad_data - 128|: upper half drops the offset bit, lower half is 128 - x
  assign w_rect     = ad_data[7] ? {1'b0, ad_data[6:0]} : 8'(8'd128 - ad_data);
  assign w_acc_next = r_acc + ACC_W'(w_rect);
  // Current sample is the last one of the window
  assign w_win_done = (r_sample_cnt == CNT_W'(SAMPLES_PER_BIT - 1));
  // Inclusive slice: a window sum equal to the threshold is a '1'
  assign w_bit      = (w_acc_next >= ACC_W'(TH));
  assign w_detect   = (w_rect >= 8'(DET_LEVEL));

  // Carrier-hunt FSM, integrator and slicer
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state       <= ST_HUNT;
      r_acc         <= '0;
      r_sample_cnt  <= '0;
      r_zero_cnt    <= '0;
      r_bit_out     <= 1'b0;
      r_bit_valid   <= 1'b0;
      r_carrier_det <= 1'b0;
    end else begin
      r_bit_valid <= 1'b0;
      if (ad_valid) begin
        case (r_state)
          ST_HUNT: begin
            // Detecting sample becomes sample 0 of the first window
            if (w_detect) begin
              r_state       <= ST_RUN;
              r_carrier_det <= 1'b1;
              r_acc         <= ACC_W'(w_rect);
              r_sample_cnt  <= CNT_W'(1);
            end
          end
          ST_RUN: begin
            if (w_win_done) begin
              r_bit_out    <= w_bit;
              r_bit_valid  <= 1'b1;
              r_acc        <= '0;
              r_sample_cnt <= '0;
              if (w_bit) begin
                r_zero_cnt <= '0;
              end else if (r_zero_cnt == ZC_W'(MAX_ZERO_BITS - 1)) begin
                // Last zero of the run is still strobed, then lock is dropped
                r_zero_cnt    <= '0;
                r_state       <= ST_HUNT;
                r_carrier_det <= 1'b0;
              end else begin
                r_zero_cnt <= r_zero_cnt + ZC_W'(1);
              end
            end else begin
              r_acc        <= w_acc_next;
              r_sample_cnt <= r_sample_cnt + CNT_W'(1);
            end
          end
          default: r_state <= ST_HUNT;
        endcase
      end
    end
  end

  assign bit_out     = r_bit_out;
  assign bit_valid   = r_bit_valid;
  assign carrier_det = r_carrier_det;

endmodule
